// File: rtl/swipt_frame_rx.sv
// Receive-side decoder for the 36-bit SWIPT downlink frame: edge-triggered bit timing,
// mid-bit sampling, preamble/parity/trailer checks. Define MAJORITY_SAMPLE_EN for 2-of-3 voting.
module swipt_frame_rx #(
  parameter int unsigned BIT_PERIOD = 200000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        din,
  output logic        busy,
  output logic        frame_valid,
  output logic [1:0]  rx_mode,
  output logic [1:0]  rx_type,
  output logic [15:0] rx_data,
  output logic        err_preamble,
  output logic        err_parity,
  output logic        err_trailer
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

`ifdef MAJORITY_SAMPLE_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  state_t            state_q, state_d;
  logic              din_m_q, din_s_q, din_d_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        bitcnt_q, bitcnt_d;
  logic [35:0]       shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              fv_q, fv_d;
  logic              ep_q, ep_d;
  logic              epar_q, epar_d;
  logic              etr_q, etr_d;
  logic [1:0]        rx_mode_q, rx_mode_d;
  logic [1:0]        rx_type_q, rx_type_d;
  logic [15:0]       rx_data_q, rx_data_d;
  logic              take_s;
  logic              bit_s;
  logic              par_ok_s;
  logic              trl_ok_s;

`ifdef MAJORITY_SAMPLE_EN
  logic [1:0]        smp_q, smp_d;
  logic              pend_q, pend_d;

  // Vote is taken the cycle after the centre sample, from the samples at counter 1 and 0.
  always_comb begin
    take_s = pend_q;
    bit_s  = maj3(smp_q[1], smp_q[0], din_s_q);
  end
`else
  // Single sample at the bit centre.
  always_comb begin
    take_s = (cnt_q == CNT_ZERO);
    bit_s  = din_s_q;
  end
`endif

  // Bits [8:4] of the word are reserved and not checked; parity sits right after the data.
  always_comb begin
    par_ok_s = (parity16(shreg_q[25:10]) == shreg_q[9]);
    trl_ok_s = (shreg_q[3:0] == 4'b0101);
  end

  // Next-state, timing counter, shift register and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    fv_d      = 1'b0;
    ep_d      = 1'b0;
    epar_d    = 1'b0;
    etr_d     = 1'b0;
    rx_mode_d = rx_mode_q;
    rx_type_d = rx_type_q;
    rx_data_d = rx_data_q;
`ifdef MAJORITY_SAMPLE_EN
    smp_d     = smp_q;
    pend_d    = 1'b0;
    if ((state_q == ST_START) || (state_q == ST_SHIFT)) begin
      if (cnt_q == CNT_ONE) begin
        smp_d[1] = din_s_q;
      end else if ((cnt_q == CNT_ZERO) && !pend_q) begin
        smp_d[0] = din_s_q;
        pend_d   = 1'b1;
      end else begin
        smp_d = smp_q;
      end
    end else begin
      smp_d = smp_q;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        bitcnt_d = 6'd0;
        if (din_s_q && !din_d_q) begin
          cnt_d   = HALF_RELOAD;
          state_d = ST_START;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_START: begin
        if (take_s) begin
          if (bit_s) begin
            shreg_d  = {shreg_q[34:0], 1'b1};
            bitcnt_d = 6'd1;
            cnt_d    = FULL_RELOAD;
            state_d  = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SHIFT: begin
        if (take_s) begin
          shreg_d  = {shreg_q[34:0], bit_s};
          bitcnt_d = bitcnt_q + 6'd1;
          cnt_d    = FULL_RELOAD;
          if ((bitcnt_d == 6'd6) && (shreg_d[5:0] != 6'b101010)) begin
            ep_d    = 1'b1;
            state_d = ST_IDLE;
          end else if (bitcnt_d == 6'd36) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_CHECK: begin
        if (par_ok_s && trl_ok_s) begin
          fv_d      = 1'b1;
          rx_mode_d = shreg_q[29:28];
          rx_type_d = shreg_q[27:26];
          rx_data_d = shreg_q[25:10];
        end else begin
          epar_d = !par_ok_s;
          etr_d  = !trl_ok_s;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; en low clears everything except the held rx fields.
  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      state_q  <= ST_IDLE;
      din_m_q  <= 1'b0;
      din_s_q  <= 1'b0;
      din_d_q  <= 1'b0;
      cnt_q    <= CNT_ZERO;
      bitcnt_q <= 6'd0;
      shreg_q  <= 36'd0;
      busy_q   <= 1'b0;
      fv_q     <= 1'b0;
      ep_q     <= 1'b0;
      epar_q   <= 1'b0;
      etr_q    <= 1'b0;
`ifdef MAJORITY_SAMPLE_EN
      smp_q    <= 2'b00;
      pend_q   <= 1'b0;
`endif
      if (!nrst) begin
        rx_mode_q <= 2'd0;
        rx_type_q <= 2'd0;
        rx_data_q <= 16'd0;
      end
    end else begin
      state_q   <= state_d;
      din_m_q   <= din;
      din_s_q   <= din_m_q;
      din_d_q   <= din_s_q;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      fv_q      <= fv_d;
      ep_q      <= ep_d;
      epar_q    <= epar_d;
      etr_q     <= etr_d;
      rx_mode_q <= rx_mode_d;
      rx_type_q <= rx_type_d;
      rx_data_q <= rx_data_d;
`ifdef MAJORITY_SAMPLE_EN
      smp_q     <= smp_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign frame_valid  = fv_q;
  assign rx_mode      = rx_mode_q;
  assign rx_type      = rx_type_q;
  assign rx_data      = rx_data_q;
  assign err_preamble = ep_q;
  assign err_parity   = epar_q;
  assign err_trailer  = etr_q;

endmodule

// File: tb/tb_swipt_frame_rx.sv
// Directed bench for swipt_frame_rx at BIT_PERIOD=16: good/bad frames, glitches, aborts.
module tb_swipt_frame_rx;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        din = 1'b0;
  logic        busy, frame_valid, err_preamble, err_parity, err_trailer;
  logic [1:0]  rx_mode, rx_type;
  logic [15:0] rx_data;

  int checks = 0;
  int errors = 0;
  int n_fv = 0, n_ep = 0, n_epar = 0, n_etr = 0, n_pair = 0, n_busy_strb = 0;
  int s_fv, s_ep, s_epar, s_etr, s_pair;

  swipt_frame_rx #(.BIT_PERIOD(P), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .din(din), .busy(busy),
    .frame_valid(frame_valid), .rx_mode(rx_mode), .rx_type(rx_type), .rx_data(rx_data),
    .err_preamble(err_preamble), .err_parity(err_parity), .err_trailer(err_trailer)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_valid)  n_fv++;
    if (err_preamble) n_ep++;
    if (err_parity)   n_epar++;
    if (err_trailer)  n_etr++;
    if (err_parity && err_trailer) n_pair++;
    if ((frame_valid || err_preamble || err_parity || err_trailer) && busy) n_busy_strb++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [5:0] pre, input logic [1:0] m,
                                     input logic [1:0] t, input logic [15:0] d,
                                     input logic par, input logic [3:0] trl);
    return {pre, m, t, d, par, 5'b00000, trl};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_fv = n_fv; s_ep = n_ep; s_epar = n_epar; s_etr = n_etr; s_pair = n_pair;
  endtask

  task automatic send(input logic [35:0] f, input int nbits);
    din = 1'b0;
    cyc(6);
    for (int i = 35; i > 35 - nbits; i--) begin
      din = f[i];
      cyc(P);
    end
  endtask

  task automatic strobes(input string tag, input int fv, input int ep,
                         input int epar, input int etr, input int pair);
    chk({tag, "_fv"},   32'(n_fv - s_fv),     32'(fv));
    chk({tag, "_ep"},   32'(n_ep - s_ep),     32'(ep));
    chk({tag, "_epar"}, 32'(n_epar - s_epar), 32'(epar));
    chk({tag, "_etr"},  32'(n_etr - s_etr),   32'(etr));
    chk({tag, "_pair"}, 32'(n_pair - s_pair), 32'(pair));
  endtask

  task automatic frame(input string tag, input logic [35:0] f, input int fv, input int ep,
                       input int epar, input int etr, input int pair);
    snap();
    send(f, 36);
    cyc(12);
    strobes(tag, fv, ep, epar, etr, pair);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic rx(input string tag, input logic [1:0] m, input logic [1:0] t,
                    input logic [15:0] d);
    chk({tag, "_mode"}, 32'(rx_mode), 32'(m));
    chk({tag, "_type"}, 32'(rx_type), 32'(t));
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
  endtask

  initial begin
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strb", 32'({frame_valid, err_preamble, err_parity, err_trailer}), 32'd0);
    rx("rst", 2'd0, 2'd0, 16'h0000);
    nrst = 1'b1;
    cyc(2);

    frame("good1", mk(6'b101010, 2'b11, 2'b01, 16'hA5C3, 1'b0, 4'b0101), 1, 0, 0, 0, 0);
    rx("good1", 2'd3, 2'd1, 16'hA5C3);

    frame("badpar", mk(6'b101010, 2'b11, 2'b01, 16'hA5C3, 1'b1, 4'b0101), 0, 0, 1, 0, 0);
    rx("badpar", 2'd3, 2'd1, 16'hA5C3);

    snap();
    send(mk(6'b101110, 2'b00, 2'b00, 16'h0000, 1'b0, 4'b0101), 6);
    din = 1'b0;
    cyc(P);
    strobes("badpre", 0, 1, 0, 0, 0);
    chk("badpre_busy", 32'(busy), 32'd0);
    rx("badpre", 2'd3, 2'd1, 16'hA5C3);

    frame("good2", mk(6'b101010, 2'b01, 2'b10, 16'h0001, 1'b1, 4'b0101), 1, 0, 0, 0, 0);
    rx("good2", 2'd1, 2'd2, 16'h0001);

    frame("badtrl", mk(6'b101010, 2'b00, 2'b00, 16'h0000, 1'b0, 4'b0111), 0, 0, 0, 1, 0);
    frame("badboth", mk(6'b101010, 2'b00, 2'b00, 16'h0000, 1'b1, 4'b0111), 0, 0, 1, 1, 1);
    rx("badboth", 2'd1, 2'd2, 16'h0001);

    // Line resting high after a frame must not start another one.
    snap();
    cyc(3 * P);
    strobes("resthi", 0, 0, 0, 0, 0);
    chk("resthi_busy", 32'(busy), 32'd0);

    // Short high glitch: receiver starts, then drops back to idle silently.
    din = 1'b0;
    cyc(6);
    snap();
    din = 1'b1;
    cyc(3);
    din = 1'b0;
    cyc(2);
    chk("glitch_busy_mid", 32'(busy), 32'd1);
    cyc(2 * P);
    strobes("glitch", 0, 0, 0, 0, 0);
    chk("glitch_busy", 32'(busy), 32'd0);

    // Reset in the middle of bit 20.
    snap();
    send(mk(6'b101010, 2'b10, 2'b01, 16'hFFFF, 1'b0, 4'b0101), 20);
    chk("nrst_busy_before", 32'(busy), 32'd1);
    nrst = 1'b0;
    din = 1'b0;
    cyc(1);
    chk("nrst_busy", 32'(busy), 32'd0);
    rx("nrst", 2'd0, 2'd0, 16'h0000);
    nrst = 1'b1;
    cyc(2 * P);
    strobes("nrst", 0, 0, 0, 0, 0);

    frame("good3", mk(6'b101010, 2'b11, 2'b01, 16'hA5C3, 1'b0, 4'b0101), 1, 0, 0, 0, 0);
    rx("good3", 2'd3, 2'd1, 16'hA5C3);

    // Disable in the middle of bit 20: rx fields are held.
    snap();
    send(mk(6'b101010, 2'b10, 2'b01, 16'hFFFF, 1'b0, 4'b0101), 20);
    en = 1'b0;
    din = 1'b0;
    cyc(1);
    chk("en_busy", 32'(busy), 32'd0);
    rx("en", 2'd3, 2'd1, 16'hA5C3);
    en = 1'b1;
    cyc(2 * P);
    strobes("en", 0, 0, 0, 0, 0);

    frame("good4", mk(6'b101010, 2'b10, 2'b11, 16'h1234, 1'b1, 4'b0101), 1, 0, 0, 0, 0);
    rx("good4", 2'd2, 2'd3, 16'h1234);

    chk("busy_at_strobe", 32'(n_busy_strb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
